// File: rtl/vga_timing_gen.sv
// Raster position counters for the 800x600 VGA path, with active-window decode, pixel coordinates and line/frame strobes.
// Latency 1 clk from an enabled edge; no backpressure, pix_en gates advance and sync_clr restarts at (0,0).
module vga_timing_gen #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 628,
    parameter int H_ACT_START = 216,
    parameter int H_ACT_END   = 1015,
    parameter int V_ACT_START = 27,
    parameter int V_ACT_END   = 626
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        sync_clr,
    output logic [10:0] count_h,
    output logic [9:0]  count_v,
    output logic        de,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        line_start,
    output logic        frame_start
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_S = 11'(H_ACT_START);
    localparam logic [10:0] H_ACT_E = 11'(H_ACT_END);
    localparam logic [9:0]  V_ACT_S = 10'(V_ACT_START);
    localparam logic [9:0]  V_ACT_E = 10'(V_ACT_END);

    logic [10:0] count_h_q, count_h_d;
    logic [9:0]  count_v_q, count_v_d;
    logic        de_q, de_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [10:0] diff_h;
    logic [9:0]  diff_v;
    logic        at_origin;

    assign at_origin = (count_h_q == 11'd0) && (count_v_q == 10'd0);

    always_comb begin
        count_h_d     = count_h_q;
        count_v_d     = count_v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (sync_clr) begin
            count_h_d     = 11'd0;
            count_v_d     = 10'd0;
            line_start_d  = !at_origin;
            frame_start_d = !at_origin;
        end else if (pix_en) begin
            // >= rather than == so a corrupted counter still falls back into range
            if (count_h_q >= H_LAST) begin
                count_h_d    = 11'd0;
                line_start_d = 1'b1;
                if (count_v_q >= V_LAST) begin
                    count_v_d     = 10'd0;
                    frame_start_d = 1'b1;
                end else begin
                    count_v_d = count_v_q + 10'd1;
                end
            end else begin
                count_h_d = count_h_q + 11'd1;
            end
        end
    end

    // Window flags come from the next position so they line up with the counters they describe.
    always_comb begin
        de_d = (count_h_d >= H_ACT_S) && (count_h_d <= H_ACT_E) &&
               (count_v_d >= V_ACT_S) && (count_v_d <= V_ACT_E);
        diff_h  = count_h_d - H_ACT_S;
        diff_v  = count_v_d - V_ACT_S;
        pix_x_d = de_d ? diff_h[9:0] : 10'd0;
        pix_y_d = de_d ? diff_v : 10'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_h_q     <= 11'd0;
            count_v_q     <= 10'd0;
            de_q          <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            count_h_q     <= count_h_d;
            count_v_q     <= count_v_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign count_h     = count_h_q;
    assign count_v     = count_v_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 800x600 VGA output path. It produces the horizontal and vertical position counters `count_h` (11 bits) and `count_v` (10 bits) consumed directly by `vga_display`. It also produces active-window flags, zero-based pixel coordinates, and line/frame start strobes for frame-buffer and ROM prefetch logic. The downstream stage derives `hsync`/`vsync` itself, so this block owns only counting and window decode.

## Interface
Parameters:
- `H_TOTAL`, 1056: pixels per line, including blanking.
- `V_TOTAL`, 628: lines per frame.
- `H_ACT_START`, 216: first active `count_h` (128 sync + 88 back porch).
- `H_ACT_END`, 1015: last active `count_h`.
- `V_ACT_START`, 27: first active `count_v` (4 sync + 23 back porch).
- `V_ACT_END`, 626: last active `count_v`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pix_en`  in  1  pixel-rate clock enable; counters advance only on `clk` edges where it is 1.
- `sync_clr`  in  1  synchronous restart of the raster to (0,0).
- `count_h`  out  11  horizontal counter, 0..H_TOTAL-1.
- `count_v`  out  10  vertical counter, 0..V_TOTAL-1.
- `de`  out  1  1 when (`count_h`, `count_v`) is inside the active window.
- `pix_x`  out  10  `count_h - H_ACT_START` when `de`, else 0.
- `pix_y`  out  10  `count_v - V_ACT_START` when `de`, else 0.
- `line_start`  out  1  one-clk strobe on entry to `count_h` = 0.
- `frame_start`  out  1  one-clk strobe on entry to (0,0).

## Operation
- Reset (`rst_n`=0, asynchronous): all outputs are 0, including `count_h`, `count_v`, `de`, `pix_x`, `pix_y`, `line_start` and `frame_start`.
- Priority on each `clk` edge, highest first: reset, then `sync_clr`, then `pix_en`, then hold.
- `sync_clr`=1: `count_h` and `count_v` load 0, regardless of `pix_en`. `line_start` and `frame_start` pulse on the following cycle only if the counters were not already at (0,0).
- `pix_en`=1 and `count_h` < H_TOTAL-1: `count_h` increments by 1.
- `pix_en`=1 and `count_h` = H_TOTAL-1: `count_h` goes to 0.
  - If `count_v` = V_TOTAL-1, `count_v` goes to 0; otherwise `count_v` increments.
- `pix_en`=0 and `sync_clr`=0: all counters hold.
- Counter arithmetic uses native widths (11 and 10 bits). No value outside the legal range is ever produced, and the counters are never allowed to overflow.
- `de` = (H_ACT_START ≤ `count_h` ≤ H_ACT_END) and (V_ACT_START ≤ `count_v` ≤ V_ACT_END). The window is 800x600.
- `pix_x` and `pix_y` are computed by subtraction truncated to 10 bits and forced to 0 outside the window.
- `de`, `pix_x`, `pix_y` and both strobes are registered: each is computed from the next counter value so that it is cycle-aligned with the `count_h`/`count_v` it describes.
- Strobes are high for exactly one `clk`, in the first cycle the counters hold the new position. They stay low while the counters are held by `pix_en`=0.
- `frame_start` implies `line_start` (both high together).
- Reset asserted mid-frame: outputs clear immediately.
- Reset release: counting resumes from (0,0) on the first `pix_en` edge. No strobe is issued for the reset state itself.

## Timing
- Latency: 1 `clk` from an enabled edge to the updated counters and flags. All outputs change only on `clk` edges, except under asynchronous reset.
- Line period: H_TOTAL enabled edges. Frame period: H_TOTAL×V_TOTAL = 663,168 enabled edges.
- Active pixels per frame: 480,000.
- `pix_en` may be any pattern, including constant 1 when `clk` is already the pixel clock. Output sequence per enabled edge is identical regardless of enable spacing.
- `sync_clr` and `pix_en` asserted in the same cycle: `sync_clr` wins, and that edge does not increment.

## Test plan
- Reset: hold `rst_n`=0 with `pix_en`=1 → all outputs 0. Release; after 1 enabled edge → `count_h`=1, `count_v`=0, no strobes.
- Window edges on line 27: at `count_h`=215 → `de`=0. At 216 → `de`=1, `pix_x`=0, `pix_y`=0. At 1015 → `pix_x`=799. At 1016 → `de`=0, `pix_x`=0. On line 626 → `pix_y`=599. On line 627 → `de`=0.
- Wraps: from (1055, 5) one enabled edge → (0, 6) with `line_start`=1 and `frame_start`=0. From (1055, 627) → (0, 0) with both strobes 1 for one clk. Frame-to-frame `frame_start` spacing is 663,168 enabled edges.
- Enable gating: `pix_en` toggled 1,0,0,1 from `count_h`=10 → counts 11, 11, 11, 12. A strobe occurring just before a `pix_en`=0 stall lasts one clk only.
- `sync_clr`: assert at (500, 300) with `pix_en`=1 → next cycle (0,0), `frame_start`=1. Assert again at (0,0) → no strobe.
- Mid-frame reset: drop `rst_n` asynchronously at (700, 400) between edges → outputs 0 before the next `clk`. Release; counting restarts from (0,0).
